// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/ack signals of ports A and B plus the shared data memory port
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          a_req_i;
    logic          b_req_i;
    logic          a_we_i;
    logic          b_we_i;
    logic [AW-1:0] a_addr_i;
    logic [AW-1:0] b_addr_i;
    logic [DW-1:0] a_wdata_i;
    logic [DW-1:0] b_wdata_i;
    logic          a_ack_o;
    logic          b_ack_o;
    logic [DW-1:0] a_rdata_o;
    logic [DW-1:0] b_rdata_o;
    logic          a_err_o;
    logic          b_err_o;
    logic          mem_read_o;
    logic          mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;

    modport slave (
        input  a_req_i, b_req_i, a_we_i, b_we_i, a_addr_i, b_addr_i, a_wdata_i, b_wdata_i, mem_rdata_i,
        output a_ack_o, b_ack_o, a_rdata_o, b_rdata_o, a_err_o, b_err_o,
        output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output a_req_i, b_req_i, a_we_i, b_we_i, a_addr_i, b_addr_i, a_wdata_i, b_wdata_i, mem_rdata_i,
        input  a_ack_o, b_ack_o, a_rdata_o, b_rdata_o, a_err_o, b_err_o,
        input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port sequencer for the data memory with a fixed LATENCY-cycle access window.
// Defining DMEM_ARB_ALIGN_CHK_EN rejects word-misaligned requests with ack+err and no memory access.
module dmem_arbiter #(
    parameter int LATENCY = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input logic         clk_i,
    input logic         rst_n_i,
    dmem_arbiter_if.slave bus
);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state;
    logic          last_b;
    logic          sel_b;
    logic          we;
    logic [CW-1:0] cnt;
    logic          grant;
    logic          grant_b;
    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic          mis;

    // on contention, B wins only if A was granted last
    assign grant   = bus.a_req_i | bus.b_req_i;
    assign grant_b = bus.b_req_i & (~bus.a_req_i | ~last_b);
    assign g_we    = grant_b ? bus.b_we_i : bus.a_we_i;
    assign g_addr  = grant_b ? bus.b_addr_i : bus.a_addr_i;
    assign g_wdata = grant_b ? bus.b_wdata_i : bus.a_wdata_i;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign mis = |g_addr[1:0];
`else
    assign mis = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= IDLE;
            last_b          <= 1'b1;
            sel_b           <= 1'b0;
            we              <= 1'b0;
            cnt             <= '0;
            bus.a_ack_o     <= 1'b0;
            bus.b_ack_o     <= 1'b0;
            bus.a_rdata_o   <= '0;
            bus.b_rdata_o   <= '0;
            bus.a_err_o     <= 1'b0;
            bus.b_err_o     <= 1'b0;
            bus.mem_read_o  <= 1'b0;
            bus.mem_write_o <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    sel_b  <= grant_b;
                    last_b <= grant_b;
                    we     <= g_we;
                    cnt    <= CW'(LATENCY - 1);
                    if (mis) begin
                        state       <= DONE;
                        bus.a_ack_o <= ~grant_b;
                        bus.b_ack_o <= grant_b;
                        bus.a_err_o <= ~grant_b;
                        bus.b_err_o <= grant_b;
                    end else begin
                        state           <= ACCESS;
                        bus.mem_read_o  <= ~g_we;
                        bus.mem_write_o <= g_we && LATENCY == 1;
                        bus.mem_addr_o  <= g_addr;
                        bus.mem_wdata_o <= g_wdata;
                    end
                end
                ACCESS: if (cnt == '0) begin
                    state           <= DONE;
                    bus.mem_read_o  <= 1'b0;
                    bus.mem_write_o <= 1'b0;
                    bus.mem_addr_o  <= '0;
                    bus.mem_wdata_o <= '0;
                    bus.a_ack_o     <= ~sel_b;
                    bus.b_ack_o     <= sel_b;
                    bus.a_rdata_o   <= (!sel_b && !we) ? bus.mem_rdata_i : '0;
                    bus.b_rdata_o   <= (sel_b && !we) ? bus.mem_rdata_i : '0;
                end else begin
                    cnt             <= cnt - 1'b1;
                    bus.mem_write_o <= we && cnt == CW'(1);
                end
                DONE: begin
                    state         <= IDLE;
                    bus.a_ack_o   <= 1'b0;
                    bus.b_ack_o   <= 1'b0;
                    bus.a_rdata_o <= '0;
                    bus.b_rdata_o <= '0;
                    bus.a_err_o   <= 1'b0;
                    bus.b_err_o   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter at LATENCY=2 and LATENCY=1 with byte-array memory models.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   wr2 = 0, rd2 = 0, wr1 = 0, rd1 = 0;
    logic [7:0] mem2 [256];
    logic [7:0] mem1 [256];

    typedef struct {
        int          d;
        bit          pb;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus2 ();
    dmem_arbiter_if #(.AW(32), .DW(32)) bus1 ();

    dmem_arbiter #(.LATENCY(2), .AW(32), .DW(32)) dut2 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus2.slave));
    dmem_arbiter #(.LATENCY(1), .AW(32), .DW(32)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus1.slave));

    assign bus2.mem_rdata_i = {mem2[bus2.mem_addr_o[7:0] + 8'd3], mem2[bus2.mem_addr_o[7:0] + 8'd2],
                               mem2[bus2.mem_addr_o[7:0] + 8'd1], mem2[bus2.mem_addr_o[7:0]]};
    assign bus1.mem_rdata_i = {mem1[bus1.mem_addr_o[7:0] + 8'd3], mem1[bus1.mem_addr_o[7:0] + 8'd2],
                               mem1[bus1.mem_addr_o[7:0] + 8'd1], mem1[bus1.mem_addr_o[7:0]]};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus2.mem_write_o) begin
            wr2 <= wr2 + 1;
            for (int i = 0; i < 4; i++) mem2[bus2.mem_addr_o[7:0] + 8'(i)] <= bus2.mem_wdata_o[8*i +: 8];
        end
        if (bus1.mem_write_o) begin
            wr1 <= wr1 + 1;
            for (int i = 0; i < 4; i++) mem1[bus1.mem_addr_o[7:0] + 8'(i)] <= bus1.mem_wdata_o[8*i +: 8];
        end
        if (bus2.mem_read_o) rd2 <= rd2 + 1;
        if (bus1.mem_read_o) rd1 <= rd1 + 1;
    end

    // scoreboard: every ack pops the oldest expectation
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic        a, b, e, oth;
            logic [31:0] r;
            exp_t        x;
            a   = d == 1 ? bus1.a_ack_o : bus2.a_ack_o;
            b   = d == 1 ? bus1.b_ack_o : bus2.b_ack_o;
            r   = d == 1 ? (b ? bus1.b_rdata_o : bus1.a_rdata_o) : (b ? bus2.b_rdata_o : bus2.a_rdata_o);
            e   = d == 1 ? (b ? bus1.b_err_o : bus1.a_err_o) : (b ? bus2.b_err_o : bus2.a_err_o);
            oth = d == 1 ? (b ? (bus1.a_ack_o | bus1.a_err_o | (|bus1.a_rdata_o)) : (bus1.b_ack_o | bus1.b_err_o | (|bus1.b_rdata_o)))
                         : (b ? (bus2.a_ack_o | bus2.a_err_o | (|bus2.a_rdata_o)) : (bus2.b_ack_o | bus2.b_err_o | (|bus2.b_rdata_o)));
            if (a || b) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack dut=%0d a_ack=%0b b_ack=%0b cyc=%0d", d, a, b, cyc);
                end else begin
                    x = q.pop_front();
                    checks++;
                    if (x.d != d || x.pb != b) begin
                        failures++;
                        $display("FAIL ack_port got dut=%0d port_b=%0b want dut=%0d port_b=%0b", d, b, x.d, x.pb);
                    end
                    checks++;
                    if (r !== x.rdata) begin
                        failures++;
                        $display("FAIL ack_rdata got %h want %h", r, x.rdata);
                    end
                    checks++;
                    if (e !== x.err) begin
                        failures++;
                        $display("FAIL ack_err got %0b want %0b", e, x.err);
                    end
                    checks++;
                    if (cyc != x.cyc) begin
                        failures++;
                        $display("FAIL ack_cycle got %0d want %0d", cyc, x.cyc);
                    end
                    checks++;
                    if (oth !== 1'b0) begin
                        failures++;
                        $display("FAIL other_port_quiet got %0b want 0", oth);
                    end
                end
            end
        end
    end

    task automatic drive(input int d, input bit pb, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (d == 1 && pb) begin bus1.b_req_i = req; bus1.b_we_i = we; bus1.b_addr_i = addr; bus1.b_wdata_i = wdata; end
        else if (d == 1) begin bus1.a_req_i = req; bus1.a_we_i = we; bus1.a_addr_i = addr; bus1.a_wdata_i = wdata; end
        else if (pb) begin bus2.b_req_i = req; bus2.b_we_i = we; bus2.b_addr_i = addr; bus2.b_wdata_i = wdata; end
        else begin bus2.a_req_i = req; bus2.a_we_i = we; bus2.a_addr_i = addr; bus2.a_wdata_i = wdata; end
    endtask

    function automatic logic ack_of(input int d, input bit pb);
        return d == 1 ? (pb ? bus1.b_ack_o : bus1.a_ack_o) : (pb ? bus2.b_ack_o : bus2.a_ack_o);
    endfunction

    // issue one transaction from an IDLE-aligned negedge, wait for its ack, leave in the next IDLE cycle
    task automatic txn(input int d, input bit pb, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        bit seen = 0;
        q.push_back('{d, pb, exp_rdata, exp_err, cyc + lat});
        drive(d, pb, 1'b1, we, addr, wdata);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = ack_of(d, pb);
        end
        drive(d, pb, 1'b0, 1'b0, 32'h0, 32'h0);
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout dut=%0d port_b=%0b got no ack want ack", d, pb);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus2.a_ack_o, bus2.b_ack_o, bus2.a_rdata_o, bus2.b_rdata_o, bus2.a_err_o, bus2.b_err_o,
             bus2.mem_read_o, bus2.mem_write_o, bus2.mem_addr_o, bus2.mem_wdata_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_lat2 got nonzero want all 0");
        end
        checks++;
        if ({bus1.a_ack_o, bus1.b_ack_o, bus1.a_rdata_o, bus1.b_rdata_o, bus1.a_err_o, bus1.b_err_o,
             bus1.mem_read_o, bus1.mem_write_o, bus1.mem_addr_o, bus1.mem_wdata_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_lat1 got nonzero want all 0");
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int w0 = wr2;
        drive(0, 0, 1'b1, 1'b1, 32'h8, 32'h12345678);
        @(negedge clk);
        checks++;
        if (bus2.mem_addr_o !== 32'h8 || bus2.mem_write_o !== 1'b0) begin
            failures++;
            $display("FAIL first_access got addr=%h write=%0b want addr=00000008 write=0", bus2.mem_addr_o, bus2.mem_write_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus2.a_ack_o, bus2.b_ack_o, bus2.a_rdata_o, bus2.b_rdata_o, bus2.a_err_o, bus2.b_err_o,
             bus2.mem_read_o, bus2.mem_write_o, bus2.mem_addr_o, bus2.mem_wdata_o} !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs got nonzero want all 0");
        end
        drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (wr2 != w0) begin
            failures++;
            $display("FAIL aborted_write_strobes got %0d want 0", wr2 - w0);
        end
        txn(0, 0, 1'b0, 32'h8, 32'h0, 32'h11223344, 1'b0, 3);
    endtask

    task automatic test_single_read();
        int r0 = rd2;
        txn(0, 0, 1'b0, 32'h4, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        checks++;
        if (rd2 - r0 != 2) begin
            failures++;
            $display("FAIL read_strobe_cycles got %0d want 2", rd2 - r0);
        end
    endtask

    task automatic test_write_read();
        int w0 = wr2;
        txn(0, 1, 1'b1, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0, 3);
        checks++;
        if (wr2 - w0 != 1) begin
            failures++;
            $display("FAIL write_strobe_cycles got %0d want 1", wr2 - w0);
        end
        txn(0, 1, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 3);
    endtask

    task automatic test_contention();
        int n = 0;
        for (int k = 0; k < 4; k++) q.push_back('{0, k % 2 == 1, 32'h01020304, 1'b0, cyc + 3 + 4 * k});
        drive(0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(0, 1, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (bus2.a_ack_o || bus2.b_ack_o) n++;
        end
        drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL contention_acks got %0d want 4", n);
            q.delete();
        end
    endtask

    task automatic test_latency1();
        int w0 = wr1;
        int r0 = rd1;
        txn(1, 0, 1'b1, 32'hC, 32'h0000AAAA, 32'h0, 1'b0, 2);
        checks++;
        if (wr1 - w0 != 1) begin
            failures++;
            $display("FAIL lat1_write_strobe got %0d want 1", wr1 - w0);
        end
        txn(1, 0, 1'b0, 32'hC, 32'h0, 32'h0000AAAA, 1'b0, 2);
        checks++;
        if (rd1 - r0 != 1) begin
            failures++;
            $display("FAIL lat1_read_strobe got %0d want 1", rd1 - r0);
        end
    endtask

    task automatic test_align();
        int r0 = rd2;
        int w0 = wr2;
        int want_rd;
`ifdef DMEM_ARB_ALIGN_CHK_EN
        want_rd = 0;
        txn(0, 0, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1);
`else
        logic [31:0] model;
        model = {mem2[9], mem2[8], mem2[7], mem2[6]};
        want_rd = 2;
        txn(0, 0, 1'b0, 32'h6, 32'h0, model, 1'b0, 3);
`endif
        checks++;
        if (rd2 - r0 != want_rd || wr2 != w0) begin
            failures++;
            $display("FAIL misaligned_strobes got rd=%0d wr=%0d want rd=%0d wr=0", rd2 - r0, wr2 - w0, want_rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem2[i] <= 8'h0;
            mem1[i] <= 8'h0;
        end
        {mem2[3], mem2[2], mem2[1], mem2[0]} <= 32'h01020304;
        {mem2[7], mem2[6], mem2[5], mem2[4]} <= 32'hDEADBEEF;
        {mem2[11], mem2[10], mem2[9], mem2[8]} <= 32'h11223344;
        drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_reset_mid_write();
        test_single_read();
        test_write_read();
        test_contention();
        test_latency1();
        test_align();
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_expectations got %0d want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
